// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet receive constants, FSM encoding and CRC-32 byte step
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_e;

  // Reflected CRC-32, one data bit per step, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - byte-wide CRC-32 register with init, enable and residue flag
module crc32_d8
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic       residue_ok_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc32_byte(crc_q, data_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign residue_ok_o = (crc_q == CRC_RESIDUE);

endmodule

// File: rtl/gmii_rx_fcs_strip.sv
// rtl/gmii_rx_fcs_strip.sv - GMII RX preamble/SFD hunt, FCS strip, CRC check and stats
module gmii_rx_fcs_strip
  import eth_pkg::*;
#(
  parameter int MAX_PREAMBLE    = 7,
  parameter int MAX_FRAME_BYTES = 2100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  gmii_data,
  output logic        gmii_data_valid,
  output logic [31:0] cnt_frame_ok,
  output logic [31:0] cnt_crc_err,
  output logic [31:0] cnt_drop
);

  localparam logic [7:0]  MAX_PRE_L   = 8'(MAX_PREAMBLE);
  localparam logic [15:0] MAX_FRAME_L = 16'(MAX_FRAME_BYTES);

  rx_state_e       state_q;
  logic            armed_q;
  logic [7:0]      pre_cnt_q;
  logic [15:0]     byte_cnt_q;
  logic [3:0][7:0] dly_q;
  logic            crc_init;
  logic            crc_en;
  logic            crc_ok;

  assign crc_init = gmii_rx_dv && (gmii_rxd == SFD_BYTE) &&
                    (((state_q == ST_IDLE) && armed_q) || (state_q == ST_PREAMBLE));
  assign crc_en   = (state_q == ST_DATA) && gmii_rx_dv && !gmii_rx_er;

  crc32_d8 u_crc (
    .clk          (clk),
    .rst          (rst),
    .init_i       (crc_init),
    .en_i         (crc_en),
    .data_i       (gmii_rxd),
    .residue_ok_o (crc_ok)
  );

  // armed_q keeps a frame cut by reset from being re-hunted until rx_dv idles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      armed_q         <= 1'b0;
      pre_cnt_q       <= '0;
      byte_cnt_q      <= '0;
      dly_q           <= '0;
      gmii_data       <= '0;
      gmii_data_valid <= 1'b0;
      cnt_frame_ok    <= '0;
      cnt_crc_err     <= '0;
      cnt_drop        <= '0;
    end else begin
      if (!gmii_rx_dv) armed_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (gmii_rx_dv && armed_q) begin
            if (gmii_rxd == PREAMBLE_BYTE) begin
              state_q   <= ST_PREAMBLE;
              pre_cnt_q <= 8'd1;
            end else if (gmii_rxd == SFD_BYTE) begin
              state_q    <= ST_DATA;
              byte_cnt_q <= '0;
              dly_q      <= '0;
            end else begin
              state_q  <= ST_DROP;
              cnt_drop <= cnt_drop + 32'd1;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state_q <= ST_IDLE;
          end else if (gmii_rxd == PREAMBLE_BYTE) begin
            if (pre_cnt_q == MAX_PRE_L) begin
              state_q  <= ST_DROP;
              cnt_drop <= cnt_drop + 32'd1;
            end else begin
              pre_cnt_q <= pre_cnt_q + 8'd1;
            end
          end else if (gmii_rxd == SFD_BYTE) begin
            state_q    <= ST_DATA;
            byte_cnt_q <= '0;
            dly_q      <= '0;
          end else begin
            state_q  <= ST_DROP;
            cnt_drop <= cnt_drop + 32'd1;
          end
        end
        ST_DATA: begin
          if (!gmii_rx_dv) begin
            gmii_data_valid <= 1'b0;
            state_q         <= ST_IDLE;
            if (byte_cnt_q < 16'd5) cnt_drop <= cnt_drop + 32'd1;
            else if (crc_ok)        cnt_frame_ok <= cnt_frame_ok + 32'd1;
            else                    cnt_crc_err <= cnt_crc_err + 32'd1;
          end else if (gmii_rx_er) begin
            gmii_data_valid <= 1'b0;
            state_q         <= ST_DROP;
            cnt_drop        <= cnt_drop + 32'd1;
          end else begin
            dly_q      <= {dly_q[2:0], gmii_rxd};
            byte_cnt_q <= byte_cnt_q + 16'd1;
            if (byte_cnt_q >= 16'd4) begin
              gmii_data       <= dly_q[3];
              gmii_data_valid <= 1'b1;
            end
            if (byte_cnt_q + 16'd1 == MAX_FRAME_L) begin
              gmii_data_valid <= 1'b0;
              state_q         <= ST_DROP;
              cnt_drop        <= cnt_drop + 32'd1;
            end
          end
        end
        ST_DROP: begin
          gmii_data_valid <= 1'b0;
          if (!gmii_rx_dv) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_fcs_strip.sv
// tb/tb_gmii_rx_fcs_strip.sv - scoreboard bench for gmii_rx_fcs_strip
module tb_gmii_rx_fcs_strip;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [7:0]  gmii_data;
  logic        gmii_data_valid;
  logic [31:0] cnt_frame_ok;
  logic [31:0] cnt_crc_err;
  logic [31:0] cnt_drop;

  gmii_rx_fcs_strip #(.MAX_PREAMBLE(7), .MAX_FRAME_BYTES(2100)) dut (
    .clk             (clk),
    .rst             (rst),
    .gmii_rxd        (gmii_rxd),
    .gmii_rx_dv      (gmii_rx_dv),
    .gmii_rx_er      (gmii_rx_er),
    .gmii_data       (gmii_data),
    .gmii_data_valid (gmii_data_valid),
    .cnt_frame_ok    (cnt_frame_ok),
    .cnt_crc_err     (cnt_crc_err),
    .cnt_drop        (cnt_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n = 0;
  int first_byte_edge = 0;
  int first_valid_edge = 0;
  int bursts = 0;
  int cur_len = 0;
  int last_len = 0;
  logic prev_v = 1'b0;
  logic [31:0] exp_ok = 0, exp_crc = 0, exp_drop = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (gmii_data_valid) begin
      if (!prev_v) begin
        bursts++;
        first_valid_edge = edge_n;
      end
      cur_len++;
      if (exp_q.size() == 0) check_eq("sb_extra_byte", gmii_data_valid, 0);
      else                   check_eq("sb_data", gmii_data, exp_q.pop_front());
    end else if (prev_v) begin
      last_len = cur_len;
      cur_len  = 0;
    end
    prev_v = gmii_data_valid;
  end

  task automatic send(input logic dv, input logic er, input logic [7:0] d);
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    gmii_rxd   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts();
    check_eq("cnt_frame_ok", cnt_frame_ok, exp_ok);
    check_eq("cnt_crc_err", cnt_crc_err, exp_crc);
    check_eq("cnt_drop", cnt_drop, exp_drop);
  endtask

  task automatic send_frame(input int npre, input int plen, input bit bad_fcs,
                            input int er_at, input int rst_at);
    logic [7:0]  fr[$];
    logic [31:0] c;
    int          n_emit;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < plen; i++) begin
      fr.push_back(8'(i));
      c = crc_upd(c, 8'(i));
    end
    c = ~c;
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
    fr.push_back(c[23:16]);
    fr.push_back(c[31:24]);
    if (bad_fcs) fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
    n_emit = fr.size() - 4;
    if (er_at > 0)   n_emit = (er_at > 5) ? er_at - 5 : 0;
    if (rst_at >= 0) n_emit = (rst_at > 4) ? rst_at - 4 : 0;
    for (int i = 0; i < n_emit; i++) exp_q.push_back(fr[i]);
    for (int i = 0; i < npre; i++) send(1'b1, 1'b0, 8'h55);
    send(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == rst_at) rst = 1'b1;
      send(1'b1, (i + 1 == er_at), fr[i]);
      if (i == 0) first_byte_edge = edge_n;
      if (i == rst_at) begin
        rst = 1'b0;
        exp_ok = 0; exp_crc = 0; exp_drop = 0;
        check_eq("rst_mid_valid", gmii_data_valid, 0);
        check_cnts();
      end
    end
    repeat (12) send(1'b0, 1'b0, 8'h00);
  endtask

  int b0;

  initial begin
    rst = 1'b1;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    gmii_rxd = 8'h00;
    repeat (3) send(1'b0, 1'b0, 8'h00);
    check_eq("reset_valid", gmii_data_valid, 0);
    check_eq("reset_data", gmii_data, 0);
    check_cnts();
    rst = 1'b0;
    repeat (2) send(1'b0, 1'b0, 8'h00);

    b0 = bursts;
    send_frame(7, 60, 1'b0, -1, -1);
    exp_ok = 1;
    check_cnts();
    check_eq("good_bursts", bursts - b0, 1);
    check_eq("good_len", last_len, 60);
    check_eq("good_latency", first_valid_edge - first_byte_edge, 4);

    b0 = bursts;
    send_frame(7, 60, 1'b1, -1, -1);
    exp_crc = 1;
    check_cnts();
    check_eq("badfcs_bursts", bursts - b0, 1);
    check_eq("badfcs_len", last_len, 60);

    b0 = bursts;
    repeat (9) send(1'b1, 1'b0, 8'h55);
    send(1'b1, 1'b0, 8'hD5);
    repeat (10) send(1'b1, 1'b0, 8'hA5);
    repeat (12) send(1'b0, 1'b0, 8'h00);
    exp_drop = 1;
    check_cnts();
    check_eq("longpre_bursts", bursts - b0, 0);

    send_frame(2, 60, 1'b0, -1, -1);
    exp_ok = 2;
    check_cnts();
    check_eq("shortpre_len", last_len, 60);

    b0 = bursts;
    send_frame(7, 96, 1'b0, 20, -1);
    exp_drop = 2;
    check_cnts();
    check_eq("rxer_bursts", bursts - b0, 1);
    check_eq("rxer_len", last_len, 15);
    send_frame(7, 60, 1'b0, -1, -1);
    exp_ok = 3;
    check_cnts();
    check_eq("after_rxer_len", last_len, 60);

    b0 = bursts;
    send_frame(7, 60, 1'b0, -1, -1);
    send_frame(7, 60, 1'b0, -1, -1);
    exp_ok = 5;
    check_cnts();
    check_eq("b2b_bursts", bursts - b0, 2);
    check_eq("b2b_len", last_len, 60);

    send_frame(7, 60, 1'b0, -1, 30);
    check_cnts();
    check_eq("rst_cut_len", last_len, 26);
    send_frame(7, 60, 1'b0, -1, -1);
    exp_ok = 1;
    check_cnts();
    check_eq("after_rst_len", last_len, 60);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
